// File: rtl/sram_1rw_param.sv
// rtl/sram_1rw_param.sv - parametrised 1RW SRAM model with masked writes, read latency 1/2, zero-init sweep
// Optional per-word even parity storage when SRAM_PARITY_EN is defined.
module sram_1rw_param #(
   parameter int WIDTH     = 17,
   parameter int DEPTH     = 1024,
   parameter int ADDR_W    = 10,
   parameter int MASK_GRAN = 1,
   parameter int RD_LAT    = 1,
   localparam int NMASK    = WIDTH / MASK_GRAN
) (
   input  logic              CE,
   input  logic              RSTB,
   input  logic              CSB,
   input  logic              WEB,
   input  logic              OEB,
   input  logic [ADDR_W-1:0] A,
   input  logic [WIDTH-1:0]  I,
   input  logic [NMASK-1:0]  BMB,
   input  logic              PINJ,
   output logic [WIDTH-1:0]  O,
   output logic              VLD,
   output logic              BUSY,
   output logic              PERR
);

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t            state, next_state;
   logic [ADDR_W-1:0] cnt, cnt_next;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  old_word;
   logic [WIDTH-1:0]  merged;
   logic              addr_ok;
   logic              init_wr;
   logic              re;
   logic              we;
   logic              rd_perr;

   assign BUSY    = (state == ST_INIT);
   assign init_wr = RSTB && (state == ST_INIT);
   assign re      = ~CSB & ~OEB & ~BUSY;
   assign we      = ~CSB & ~WEB & ~BUSY;
   assign addr_ok = (32'(A) < DEPTH);
   assign old_word = addr_ok ? mem[A] : '0;

   always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      case (state)
         ST_INIT: begin
            cnt_next = cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1)) begin
               next_state = ST_IDLE;
               cnt_next   = '0;
            end
         end
         default: ;
      endcase
   end

   // Unmasked groups take new data; masked groups keep the stored word.
   always_comb begin
      merged = old_word;
      for (int g = 0; g < NMASK; g++) begin
         if (!BMB[g]) merged[g*MASK_GRAN +: MASK_GRAN] = I[g*MASK_GRAN +: MASK_GRAN];
      end
   end

   always_ff @(posedge CE) begin
      if (init_wr)
         mem[cnt] <= '0;
      else if (we && addr_ok)
         mem[A] <= merged;
   end

`ifdef SRAM_PARITY_EN
   logic par_mem [DEPTH];
   logic old_par;

   assign old_par = addr_ok ? par_mem[A] : 1'b0;
   assign rd_perr = addr_ok & ((^old_word) ^ old_par);

   always_ff @(posedge CE) begin
      if (init_wr)
         par_mem[cnt] <= 1'b0;
      else if (we && addr_ok)
         par_mem[A] <= (^merged) ^ PINJ;
   end
`else
   logic unused_pinj;
   assign unused_pinj = PINJ;
   assign rd_perr     = 1'b0;
`endif

   // Read data is taken from old_word, so a same-edge write is seen only by later reads.
   if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s1_data;
      logic             s1_vld;
      logic             s1_perr;

      always_ff @(posedge CE or negedge RSTB) begin
         if (!RSTB) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
            s1_perr <= 1'b0;
            O       <= '0;
            VLD     <= 1'b0;
            PERR    <= 1'b0;
         end else begin
            s1_vld  <= re;
            s1_perr <= re & rd_perr;
            if (re) s1_data <= old_word;
            VLD  <= s1_vld;
            PERR <= s1_perr;
            if (s1_vld) O <= s1_data;
         end
      end
   end else begin : g_lat1
      always_ff @(posedge CE or negedge RSTB) begin
         if (!RSTB) begin
            O    <= '0;
            VLD  <= 1'b0;
            PERR <= 1'b0;
         end else begin
            VLD  <= re;
            PERR <= re & rd_perr;
            if (re) O <= old_word;
         end
      end
   end

endmodule

// File: tb/tb_sram_1rw_param.sv
// tb/tb_sram_1rw_param.sv - directed bench for sram_1rw_param, latency 1 and 2 instances side by side
module tb_sram_1rw_param;

   logic        CE = 1'b0;
   logic        RSTB, CSB, WEB, OEB, PINJ;
   logic [9:0]  A;
   logic [16:0] I, BMB;
   logic [16:0] O1, O2;
   logic        VLD1, VLD2, BUSY1, BUSY2, PERR1, PERR2;
   int          checks = 0;
   int          failures = 0;

   always #5 CE = ~CE;

   sram_1rw_param #(.RD_LAT(1)) u_lat1 (
      .CE(CE), .RSTB(RSTB), .CSB(CSB), .WEB(WEB), .OEB(OEB), .A(A), .I(I), .BMB(BMB),
      .PINJ(PINJ), .O(O1), .VLD(VLD1), .BUSY(BUSY1), .PERR(PERR1)
   );

   sram_1rw_param #(.RD_LAT(2)) u_lat2 (
      .CE(CE), .RSTB(RSTB), .CSB(CSB), .WEB(WEB), .OEB(OEB), .A(A), .I(I), .BMB(BMB),
      .PINJ(PINJ), .O(O2), .VLD(VLD2), .BUSY(BUSY2), .PERR(PERR2)
   );

   task automatic do_write(input logic [9:0] addr, input logic [16:0] data,
                           input logic [16:0] mask, input logic pinj);
      @(negedge CE);
      CSB = 0; WEB = 0; OEB = 1; A = addr; I = data; BMB = mask; PINJ = pinj;
      @(negedge CE);
      CSB = 1; WEB = 1; PINJ = 0; BMB = '1;
   endtask

   task automatic do_read(input logic [9:0] addr, output logic [16:0] o1, output logic v1,
                          output logic p1, output logic v2a, output logic v1n,
                          output logic [16:0] o2, output logic v2, output logic p2);
      @(negedge CE);
      CSB = 0; OEB = 0; WEB = 1; A = addr;
      @(posedge CE); #1;
      o1 = O1; v1 = VLD1; p1 = PERR1; v2a = VLD2;
      @(negedge CE);
      CSB = 1; OEB = 1;
      @(posedge CE); #1;
      v1n = VLD1; o2 = O2; v2 = VLD2; p2 = PERR2;
   endtask

   task automatic wait_busy(output int n, output logic vld_seen);
      n = 0;
      vld_seen = 0;
      for (int k = 0; k < 2000; k++) begin
         @(posedge CE); #1;
         n++;
         if (VLD1 || VLD2) vld_seen = 1;
         if (!BUSY1) break;
      end
   endtask

   task automatic test_reset();
      int   n;
      logic vs;
      RSTB = 0; CSB = 1; WEB = 1; OEB = 1; A = 0; I = 0; BMB = '1; PINJ = 0;
      repeat (3) @(posedge CE);
      #1;
      checks++; if (O1 !== 17'h0) begin failures++; $display("FAIL rst_o got=%h exp=%h", O1, 17'h0); end
      checks++; if (VLD1 !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", VLD1); end
      checks++; if (BUSY1 !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", BUSY1); end
      checks++; if (PERR1 !== 1'b0) begin failures++; $display("FAIL rst_perr got=%b exp=0", PERR1); end
      checks++; if (VLD2 !== 1'b0) begin failures++; $display("FAIL rst_vld2 got=%b exp=0", VLD2); end
      @(negedge CE);
      CSB = 0; OEB = 0; A = 3; RSTB = 1;
      wait_busy(n, vs);
      CSB = 1; OEB = 1;
      checks++; if (n !== 1024) begin failures++; $display("FAIL busy_edges got=%0d exp=1024", n); end
      checks++; if (vs !== 1'b0) begin failures++; $display("FAIL vld_while_busy got=%b exp=0", vs); end
   endtask

   task automatic test_init_read();
      logic [16:0] o1, o2;
      logic        v1, p1, v2a, v1n, v2, p2;
      logic [9:0]  addrs [2];
      addrs[0] = 10'd0;
      addrs[1] = 10'd1023;
      for (int k = 0; k < 2; k++) begin
         do_read(addrs[k], o1, v1, p1, v2a, v1n, o2, v2, p2);
         checks++; if (o1 !== 17'h0) begin failures++; $display("FAIL init_rd_o a=%0d got=%h exp=0", addrs[k], o1); end
         checks++; if (v1 !== 1'b1) begin failures++; $display("FAIL init_rd_vld a=%0d got=%b exp=1", addrs[k], v1); end
         checks++; if (v1n !== 1'b0) begin failures++; $display("FAIL init_rd_vld_width a=%0d got=%b exp=0", addrs[k], v1n); end
         checks++; if (v2a !== 1'b0 || v2 !== 1'b1) begin
            failures++; $display("FAIL init_rd_lat2_vld a=%0d got=%b%b exp=01", addrs[k], v2a, v2);
         end
         checks++; if (o2 !== 17'h0) begin failures++; $display("FAIL init_rd_o2 a=%0d got=%h exp=0", addrs[k], o2); end
      end
   endtask

   task automatic test_write_read();
      logic [16:0] o1, o2;
      logic        v1, p1, v2a, v1n, v2, p2;
      do_write(10'd5, 17'h1ABCD, 17'h0, 1'b0);
      do_read(10'd5, o1, v1, p1, v2a, v1n, o2, v2, p2);
      checks++; if (o1 !== 17'h1ABCD) begin failures++; $display("FAIL wr_rd_o got=%h exp=%h", o1, 17'h1ABCD); end
      checks++; if (v1 !== 1'b1) begin failures++; $display("FAIL wr_rd_vld got=%b exp=1", v1); end
      checks++; if (v2a !== 1'b0) begin failures++; $display("FAIL wr_rd_lat2_early got=%b exp=0", v2a); end
      checks++; if (o2 !== 17'h1ABCD || v2 !== 1'b1) begin
         failures++; $display("FAIL wr_rd_lat2 got=%h/%b exp=%h/1", o2, v2, 17'h1ABCD);
      end
   endtask

   task automatic test_back_to_back();
      do_write(10'd6, 17'h0F0F0, 17'h0, 1'b0);
      @(negedge CE);
      CSB = 0; OEB = 0; WEB = 1; A = 10'd5;
      @(posedge CE); #1;
      checks++; if (O1 !== 17'h1ABCD || VLD1 !== 1'b1) begin
         failures++; $display("FAIL b2b_first got=%h/%b exp=%h/1", O1, VLD1, 17'h1ABCD);
      end
      @(negedge CE);
      A = 10'd6;
      @(posedge CE); #1;
      checks++; if (O1 !== 17'h0F0F0 || VLD1 !== 1'b1) begin
         failures++; $display("FAIL b2b_second got=%h/%b exp=%h/1", O1, VLD1, 17'h0F0F0);
      end
      checks++; if (O2 !== 17'h1ABCD || VLD2 !== 1'b1) begin
         failures++; $display("FAIL b2b_lat2_first got=%h/%b exp=%h/1", O2, VLD2, 17'h1ABCD);
      end
      @(negedge CE);
      CSB = 1; OEB = 1;
      @(posedge CE); #1;
      checks++; if (O1 !== 17'h0F0F0 || VLD1 !== 1'b0) begin
         failures++; $display("FAIL b2b_hold got=%h/%b exp=%h/0", O1, VLD1, 17'h0F0F0);
      end
      checks++; if (O2 !== 17'h0F0F0 || VLD2 !== 1'b1) begin
         failures++; $display("FAIL b2b_lat2_second got=%h/%b exp=%h/1", O2, VLD2, 17'h0F0F0);
      end
      @(posedge CE); #1;
      checks++; if (VLD2 !== 1'b0 || O2 !== 17'h0F0F0) begin
         failures++; $display("FAIL b2b_lat2_hold got=%h/%b exp=%h/0", O2, VLD2, 17'h0F0F0);
      end
   endtask

   task automatic test_mask();
      logic [16:0] o1, o2;
      logic        v1, p1, v2a, v1n, v2, p2;
      do_write(10'd7, 17'h1FFFF, 17'h1FF00, 1'b0);
      do_read(10'd7, o1, v1, p1, v2a, v1n, o2, v2, p2);
      checks++; if (o1 !== 17'h000FF) begin failures++; $display("FAIL mask_set got=%h exp=%h", o1, 17'h000FF); end
      do_write(10'd7, 17'h00000, 17'h1FFFE, 1'b0);
      do_read(10'd7, o1, v1, p1, v2a, v1n, o2, v2, p2);
      checks++; if (o1 !== 17'h000FE) begin failures++; $display("FAIL mask_clr got=%h exp=%h", o1, 17'h000FE); end
      checks++; if (o2 !== 17'h000FE) begin failures++; $display("FAIL mask_clr_lat2 got=%h exp=%h", o2, 17'h000FE); end
   endtask

   task automatic test_rbw();
      logic [16:0] o1, o2;
      logic        v1, p1, v2a, v1n, v2, p2;
      do_write(10'd9, 17'h00011, 17'h0, 1'b0);
      @(negedge CE);
      CSB = 0; WEB = 0; OEB = 0; A = 10'd9; I = 17'h00022; BMB = 17'h0;
      @(posedge CE); #1;
      checks++; if (O1 !== 17'h00011 || VLD1 !== 1'b1) begin
         failures++; $display("FAIL rbw_old got=%h/%b exp=%h/1", O1, VLD1, 17'h00011);
      end
      @(negedge CE);
      CSB = 1; WEB = 1; OEB = 1; BMB = '1;
      @(posedge CE); #1;
      checks++; if (O2 !== 17'h00011) begin failures++; $display("FAIL rbw_old_lat2 got=%h exp=%h", O2, 17'h00011); end
      do_read(10'd9, o1, v1, p1, v2a, v1n, o2, v2, p2);
      checks++; if (o1 !== 17'h00022) begin failures++; $display("FAIL rbw_new got=%h exp=%h", o1, 17'h00022); end
   endtask

   task automatic test_parity();
      logic [16:0] o1, o2;
      logic        v1, p1, v2a, v1n, v2, p2;
      do_write(10'd4, 17'h00003, 17'h0, 1'b1);
      do_read(10'd4, o1, v1, p1, v2a, v1n, o2, v2, p2);
`ifdef SRAM_PARITY_EN
      checks++; if (p1 !== 1'b1 || v1 !== 1'b1) begin failures++; $display("FAIL par_inj got=%b/%b exp=1/1", p1, v1); end
      checks++; if (p2 !== 1'b1) begin failures++; $display("FAIL par_inj_lat2 got=%b exp=1", p2); end
      do_write(10'd4, 17'h00003, 17'h0, 1'b0);
      do_read(10'd4, o1, v1, p1, v2a, v1n, o2, v2, p2);
      checks++; if (p1 !== 1'b0) begin failures++; $display("FAIL par_clean got=%b exp=0", p1); end
      checks++; if (p2 !== 1'b0) begin failures++; $display("FAIL par_clean_lat2 got=%b exp=0", p2); end
`else
      checks++; if (p1 !== 1'b0 || p2 !== 1'b0) begin failures++; $display("FAIL par_off got=%b%b exp=00", p1, p2); end
      checks++; if (o1 !== 17'h00003) begin failures++; $display("FAIL par_off_data got=%h exp=%h", o1, 17'h00003); end
`endif
   endtask

   task automatic test_reset_mid_sweep();
      logic [16:0] o1, o2;
      logic        v1, p1, v2a, v1n, v2, p2;
      int          n;
      logic        vs;
      do_write(10'd20, 17'h1ABCD, 17'h0, 1'b0);
      do_read(10'd20, o1, v1, p1, v2a, v1n, o2, v2, p2);
      checks++; if (o1 !== 17'h1ABCD) begin failures++; $display("FAIL pre_rst_data got=%h exp=%h", o1, 17'h1ABCD); end
      @(negedge CE);
      RSTB = 0;
      #1;
      checks++; if (O1 !== 17'h0 || O2 !== 17'h0) begin failures++; $display("FAIL async_rst_o got=%h/%h exp=0/0", O1, O2); end
      checks++; if (BUSY1 !== 1'b1 || VLD1 !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%b/%b exp=1/0", BUSY1, VLD1); end
      @(negedge CE);
      RSTB = 1;
      repeat (300) @(posedge CE);
      #2;
      RSTB = 0;
      #1;
      checks++; if (BUSY1 !== 1'b1 || VLD1 !== 1'b0 || O1 !== 17'h0) begin
         failures++; $display("FAIL mid_sweep_rst got=%b/%b/%h exp=1/0/0", BUSY1, VLD1, O1);
      end
      @(negedge CE);
      CSB = 0; OEB = 0; A = 10'd3; RSTB = 1;
      wait_busy(n, vs);
      CSB = 1; OEB = 1;
      checks++; if (n !== 1024) begin failures++; $display("FAIL resweep_edges got=%0d exp=1024", n); end
      checks++; if (vs !== 1'b0) begin failures++; $display("FAIL resweep_vld got=%b exp=0", vs); end
      do_read(10'd20, o1, v1, p1, v2a, v1n, o2, v2, p2);
      checks++; if (o1 !== 17'h0 || v1 !== 1'b1) begin
         failures++; $display("FAIL resweep_clear got=%h/%b exp=0/1", o1, v1);
      end
   endtask

   initial begin
      test_reset();
      test_init_read();
      test_write_read();
      test_back_to_back();
      test_mask();
      test_rbw();
      test_parity();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
